// File: rtl/line_buffer_window_ctrl.sv
// Circular line-buffer controller: tracks write slot, window head, fill level
// and row position for a KER_SIZE-column sliding window with configurable stride.
module line_buffer_window_ctrl #(
    parameter int KER_SIZE = 3,
    parameter int STRIDE_W = 2,
    parameter int COL_W    = 10,
    localparam int PTR_W   = (KER_SIZE > 2) ? $clog2(KER_SIZE) : 1,
    localparam int FILL_W  = $clog2(KER_SIZE + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    input  logic [STRIDE_W-1:0] cfg_stride,
    input  logic [COL_W-1:0]    cfg_row_len,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [PTR_W-1:0]    col_ptr,
    output logic                win_valid,
    input  logic                win_ready,
    output logic [PTR_W-1:0]    head_ptr,
    output logic [FILL_W-1:0]   fill_cnt,
    output logic [COL_W-1:0]    col_idx,
    output logic                row_done
);

    localparam int IW = COL_W + 1;

    typedef enum logic [1:0] {FILL, WIN, ADV, DONE} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    col_ptr_q, col_ptr_d;
    logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [COL_W-1:0]    col_idx_q, col_idx_d;
    logic [STRIDE_W-1:0] skip_q, skip_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic [COL_W-1:0]    row_len_q, row_len_d;

    logic                first_col;
    logic                accept;
    logic [STRIDE_W-1:0] live_stride;
    logic [STRIDE_W-1:0] stride_eff;
    logic [COL_W-1:0]    row_len_eff;
    logic [PTR_W-1:0]    col_ptr_inc;
    logic [COL_W-1:0]    col_idx_inc;
    logic [FILL_W-1:0]   fill_inc;
    logic [IW-1:0]       idx_plus_stride;

    assign in_ready  = (state_q == FILL) || (state_q == ADV);
    assign win_valid = (state_q == WIN);
    assign row_done  = (state_q == DONE);
    assign col_ptr   = col_ptr_q;
    assign head_ptr  = col_ptr_q;
    assign fill_cnt  = fill_cnt_q;
    assign col_idx   = col_idx_q;

    // On the first column of a row the live config drives decisions; it is latched then.
    assign first_col       = (col_idx_q == '0);
    assign live_stride     = (cfg_stride == '0) ? STRIDE_W'(1) : cfg_stride;
    assign stride_eff      = first_col ? live_stride : stride_q;
    assign row_len_eff     = first_col ? cfg_row_len : row_len_q;
    assign accept          = in_valid & in_ready;
    assign col_ptr_inc     = (col_ptr_q == PTR_W'(KER_SIZE - 1)) ? '0 : col_ptr_q + PTR_W'(1);
    assign col_idx_inc     = col_idx_q + COL_W'(1);
    assign fill_inc        = fill_cnt_q + FILL_W'(1);
    assign idx_plus_stride = {1'b0, col_idx_q} + IW'(stride_eff);

    always_comb begin
        state_d    = state_q;
        col_ptr_d  = col_ptr_q;
        fill_cnt_d = fill_cnt_q;
        col_idx_d  = col_idx_q;
        skip_d     = skip_q;
        stride_d   = stride_q;
        row_len_d  = row_len_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    col_ptr_d  = col_ptr_inc;
                    col_idx_d  = col_idx_inc;
                    fill_cnt_d = fill_inc;
                    if (first_col) begin
                        stride_d  = live_stride;
                        row_len_d = cfg_row_len;
                    end
                    if (fill_inc == FILL_W'(KER_SIZE))
                        state_d = WIN;
                    else if (col_idx_inc >= row_len_eff)
                        state_d = DONE;
                end
            end
            WIN: begin
                if (win_ready) begin
                    if (idx_plus_stride > {1'b0, row_len_eff}) begin
                        state_d = DONE;
                    end else begin
                        skip_d  = stride_eff;
                        state_d = ADV;
                    end
                end
            end
            ADV: begin
                if (accept) begin
                    col_ptr_d  = col_ptr_inc;
                    col_idx_d  = col_idx_inc;
                    fill_cnt_d = (fill_cnt_q == FILL_W'(KER_SIZE)) ? fill_cnt_q : fill_inc;
                    skip_d     = skip_q - STRIDE_W'(1);
                    if (skip_q == STRIDE_W'(1))
                        state_d = WIN;
                end
            end
            DONE: begin
                col_ptr_d  = '0;
                fill_cnt_d = '0;
                col_idx_d  = '0;
                state_d    = FILL;
            end
            default: state_d = FILL;
        endcase

        if (flush) begin
            state_d    = FILL;
            col_ptr_d  = '0;
            fill_cnt_d = '0;
            col_idx_d  = '0;
            skip_d     = '0;
            stride_d   = '0;
            row_len_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= FILL;
            col_ptr_q  <= '0;
            fill_cnt_q <= '0;
            col_idx_q  <= '0;
            skip_q     <= '0;
            stride_q   <= '0;
            row_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            col_ptr_q  <= col_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            col_idx_q  <= col_idx_d;
            skip_q     <= skip_d;
            stride_q   <= stride_d;
            row_len_q  <= row_len_d;
        end
    end

endmodule

// File: tb/tb_line_buffer_window_ctrl.sv
// Directed, table-driven bench for line_buffer_window_ctrl with KER_SIZE=3.
module tb_line_buffer_window_ctrl;

    logic       clk;
    logic       rstn;
    logic       flush;
    logic [1:0] cfg_stride;
    logic [9:0] cfg_row_len;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] col_ptr;
    logic       win_valid;
    logic       win_ready;
    logic [1:0] head_ptr;
    logic [1:0] fill_cnt;
    logic [9:0] col_idx;
    logic       row_done;

    int n_cmp;
    int n_bad;

    line_buffer_window_ctrl #(
        .KER_SIZE (3),
        .STRIDE_W (2),
        .COL_W    (10)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .cfg_stride  (cfg_stride),
        .cfg_row_len (cfg_row_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .col_ptr     (col_ptr),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .head_ptr    (head_ptr),
        .fill_cnt    (fill_cnt),
        .col_idx     (col_idx),
        .row_done    (row_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       fl;
        logic       iv;
        logic       wr;
        logic [1:0] st;
        logic [9:0] rl;
        logic       e_ir;
        logic       e_wv;
        logic       e_rd;
        logic [1:0] e_cp;
        logic [1:0] e_fc;
        logic [9:0] e_ci;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic fl, input logic iv, input logic wr,
                                input logic [1:0] st, input logic [9:0] rl,
                                input logic e_ir, input logic e_wv, input logic e_rd,
                                input logic [1:0] e_cp, input logic [1:0] e_fc,
                                input logic [9:0] e_ci);
        vec_t v;
        v.fl = fl; v.iv = iv; v.wr = wr; v.st = st; v.rl = rl;
        v.e_ir = e_ir; v.e_wv = e_wv; v.e_rd = e_rd;
        v.e_cp = e_cp; v.e_fc = e_fc; v.e_ci = e_ci;
        return v;
    endfunction

    task automatic check_outs(input string name, input logic e_ir, input logic e_wv,
                              input logic e_rd, input logic [1:0] e_cp,
                              input logic [1:0] e_fc, input logic [9:0] e_ci);
        logic [16:0] act;
        logic [16:0] exp;
        act = {in_ready, win_valid, row_done, col_ptr, fill_cnt, col_idx};
        exp = {e_ir, e_wv, e_rd, e_cp, e_fc, e_ci};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got ir=%b wv=%b rd=%b cp=%0d fc=%0d ci=%0d, expected ir=%b wv=%b rd=%b cp=%0d fc=%0d ci=%0d",
                     name, in_ready, win_valid, row_done, col_ptr, fill_cnt, col_idx,
                     e_ir, e_wv, e_rd, e_cp, e_fc, e_ci);
        end
        if (e_wv) begin
            n_cmp++;
            if (head_ptr !== e_cp) begin
                n_bad++;
                $display("FAIL %s head_ptr: got %0d, expected %0d", name, head_ptr, e_cp);
            end
        end
    endtask

    // Outputs are decoded from registered state, so they are checked before the edge.
    task automatic apply_vec(input vec_t v, input string name);
        flush       = v.fl;
        in_valid    = v.iv;
        win_ready   = v.wr;
        cfg_stride  = v.st;
        cfg_row_len = v.rl;
        #1;
        check_outs(name, v.e_ir, v.e_wv, v.e_rd, v.e_cp, v.e_fc, v.e_ci);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; win_ready = 1'b0;
        cfg_stride = 2'd1; cfg_row_len = 10'd5;

        // row 1: stride 1, length 5 -> heads 0,1,2
        tbl.push_back(mk(0,1,1,1,5, 1,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,5, 1,0,0,1,1,1));
        tbl.push_back(mk(0,1,1,1,5, 1,0,0,2,2,2));
        tbl.push_back(mk(0,1,1,1,5, 0,1,0,0,3,3));
        tbl.push_back(mk(0,1,1,1,5, 1,0,0,0,3,3));
        tbl.push_back(mk(0,1,1,1,5, 0,1,0,1,3,4));
        tbl.push_back(mk(0,1,1,1,5, 1,0,0,1,3,4));
        tbl.push_back(mk(0,1,1,1,5, 0,1,0,2,3,5));
        tbl.push_back(mk(0,1,1,1,5, 0,0,1,2,3,5));
        // row 2: stride 2, length 7 latched; cfg changed mid-row -> heads 0,2,1
        tbl.push_back(mk(0,1,1,2,7, 1,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,3, 1,0,0,1,1,1));
        tbl.push_back(mk(0,1,1,1,3, 1,0,0,2,2,2));
        tbl.push_back(mk(0,1,1,1,3, 0,1,0,0,3,3));
        tbl.push_back(mk(0,1,1,1,3, 1,0,0,0,3,3));
        tbl.push_back(mk(0,1,1,1,3, 1,0,0,1,3,4));
        tbl.push_back(mk(0,1,1,1,3, 0,1,0,2,3,5));
        tbl.push_back(mk(0,1,1,1,3, 1,0,0,2,3,5));
        tbl.push_back(mk(0,1,1,1,3, 1,0,0,0,3,6));
        tbl.push_back(mk(0,1,1,1,3, 0,1,0,1,3,7));
        tbl.push_back(mk(0,1,1,1,3, 0,0,1,1,3,7));
        // row 3: short row of 2 columns, no window
        tbl.push_back(mk(0,1,1,1,2, 1,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,2, 1,0,0,1,1,1));
        tbl.push_back(mk(0,1,1,1,2, 0,0,1,2,2,2));
        // row 4: stride 0 acts as 1, length 4; later cfg changes ignored
        tbl.push_back(mk(0,1,1,0,4,  1,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,3,10, 1,0,0,1,1,1));
        tbl.push_back(mk(0,1,1,3,10, 1,0,0,1,1,1));
        tbl.push_back(mk(0,1,1,3,10, 1,0,0,2,2,2));
        tbl.push_back(mk(0,1,1,3,10, 0,1,0,0,3,3));
        tbl.push_back(mk(0,1,1,3,10, 1,0,0,0,3,3));
        tbl.push_back(mk(0,1,1,3,10, 0,1,0,1,3,4));
        tbl.push_back(mk(0,1,1,3,10, 0,0,1,1,3,4));
        tbl.push_back(mk(0,0,1,3,10, 1,0,0,0,0,0));

        #1;
        check_outs("reset_state", 1, 0, 0, 0, 0, 0);
        #12;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++)
            apply_vec(tbl[i], $sformatf("tbl[%0d]", i));

        // stall: win_ready low for 5 cycles in WIN, then ADV with in_valid gaps
        apply_vec(mk(0,1,0,1,5, 1,0,0,0,0,0), "stall_fill0");
        apply_vec(mk(0,1,0,1,5, 1,0,0,1,1,1), "stall_fill1");
        apply_vec(mk(0,1,0,1,5, 1,0,0,2,2,2), "stall_fill2");
        for (int i = 0; i < 5; i++)
            apply_vec(mk(0,1,0,1,5, 0,1,0,0,3,3), $sformatf("stall_hold%0d", i));
        apply_vec(mk(0,1,1,1,5, 0,1,0,0,3,3), "stall_release");
        apply_vec(mk(0,0,1,1,5, 1,0,0,0,3,3), "adv_gap0");
        apply_vec(mk(0,0,1,1,5, 1,0,0,0,3,3), "adv_gap1");
        apply_vec(mk(0,1,1,1,5, 1,0,0,0,3,3), "adv_accept");
        apply_vec(mk(0,1,1,1,5, 0,1,0,1,3,4), "win2");

        // flush while in ADV: reset values next cycle, no row_done
        apply_vec(mk(1,1,1,1,5, 1,0,0,1,3,4), "flush_in_adv");
        apply_vec(mk(0,1,0,1,5, 1,0,0,0,0,0), "after_flush");
        apply_vec(mk(0,1,0,1,5, 1,0,0,1,1,1), "flush_row_c1");
        apply_vec(mk(0,1,0,1,5, 1,0,0,2,2,2), "flush_row_c2");
        apply_vec(mk(0,1,0,1,5, 0,1,0,0,3,3), "flush_row_win");

        // async reset pulse while in WIN: immediate reset values
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check_outs("async_reset_in_win", 1, 0, 0, 0, 0, 0);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        apply_vec(mk(0,0,1,1,5, 1,0,0,0,0,0), "post_reset_idle");
        apply_vec(mk(0,1,1,1,5, 1,0,0,0,0,0), "post_reset_accept");
        apply_vec(mk(0,0,1,1,5, 1,0,0,1,1,1), "post_reset_c1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
